// File: rtl/computation_pkg.sv
// Shared definitions for the computation engine.
// Mode encoding, FSM states and the saturation helper.
package computation_pkg;

  localparam int MAX_W = 64;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_EMIT
  } state_t;

  typedef logic signed [2*MAX_W-1:0] wide_t;

  // {high, low}: does v fall outside the signed range of a w-bit lane
  function automatic logic [1:0] sat_flags(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = ~hi;
    sat_flags = {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job FIFO with asynchronous reset.
// Push on full and pop on empty are ignored.
module job_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/computation_engine.sv
// Lane-serial saturating arithmetic engine.
// Jobs queue in a FIFO and results leave on a valid/ready port.
module computation_engine
  import computation_pkg::*;
#(
  parameter int LANE_W     = 32,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2*LANES*LANE_W-1:0] rx_data,
  input  logic [1:0]                rx_mode,
  input  logic                      rx_irq,
  output logic                      rx_full,
  output logic                      rx_drop,
  output logic [LANES*LANE_W-1:0]   tx_data,
  output logic                      tx_wr_out,
  input  logic                      tx_ready,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      busy
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int JOB_W = 2 + 2 * VEC_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                    state_q;
  state_t                    state_d;
  logic                      pop;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [JOB_W-1:0]          fifo_dout;
  logic [JOB_W-1:0]          job_q;
  logic [IDX_W-1:0]          idx_q;
  logic [VEC_W-1:0]          res_q;
  logic                      ovf_q;
  logic                      unf_q;
  logic                      drop_q;
  logic                      last_lane;
  logic [1:0]                mode;
  logic [LANE_W-1:0]         a_lane;
  logic [LANE_W-1:0]         b_lane;
  logic signed [2*LANE_W-1:0] prod;
  wide_t                     a_x;
  wide_t                     b_x;
  wide_t                     full_r;
  logic [1:0]                flags;
  logic [LANE_W-1:0]         lane_res;

  job_fifo #(
    .W     (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_irq),
    .pop   (pop),
    .din   ({rx_mode, rx_data}),
    .dout  (fifo_dout),
    .full  (rx_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mode      = job_q[JOB_W-1 -: 2];
  assign a_lane    = job_q[VEC_W + idx_q*LANE_W +: LANE_W];
  assign b_lane    = job_q[idx_q*LANE_W +: LANE_W];
  assign last_lane = idx_q == IDX_W'(LANES - 1);

  // full-precision lane result, then clamp to the lane range
  always_comb begin
    a_x    = wide_t'($signed(a_lane));
    b_x    = wide_t'($signed(b_lane));
    prod   = $signed(a_lane) * $signed(b_lane);
    full_r = '0;
    unique case (mode)
      MODE_ADD: full_r = a_x + b_x;
      MODE_SUB: full_r = a_x - b_x;
      MODE_MUL: full_r = wide_t'(prod);
      MODE_MAX: full_r = (a_x > b_x) ? a_x : b_x;
      default:  full_r = '0;
    endcase
    flags    = sat_flags(full_r, LANE_W);
    lane_res = full_r[LANE_W-1:0];
    if (flags[1])
      lane_res = {1'b0, {(LANE_W-1){1'b1}}};
    else if (flags[0])
      lane_res = {1'b1, {(LANE_W-1){1'b0}}};
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state and FIFO pop
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: if (last_lane) state_d = ST_EMIT;
      ST_EMIT: if (tx_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // job capture and one lane per cycle into the result register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      job_q <= '0;
      idx_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            job_q <= fifo_dout;
            idx_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
          end
        end
        ST_CALC: begin
          res_q[idx_q*LANE_W +: LANE_W] <= lane_res;
          ovf_q <= ovf_q | flags[1];
          unf_q <= unf_q | flags[0];
          idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // a strobe into a full FIFO is remembered until reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 drop_q <= 1'b0;
    else if (rx_irq && rx_full) drop_q <= 1'b1;
  end

  assign rx_drop   = drop_q;
  assign tx_data   = res_q;
  assign tx_wr_out = state_q == ST_EMIT;
  assign overflow  = ovf_q & tx_wr_out;
  assign underflow = unf_q & tx_wr_out;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_computation_engine.sv
// Self-checking bench for computation_engine.
// Directed cases plus random jobs against a lane-level reference model.
module tb_computation_engine;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] rx_data;
  logic [1:0]   rx_mode;
  logic         rx_irq;
  logic         rx_full;
  logic         rx_drop;
  logic [63:0]  tx_data;
  logic         tx_wr_out;
  logic         tx_ready;
  logic         overflow;
  logic         underflow;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  computation_engine #(
    .LANE_W     (32),
    .LANES      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_mode   (rx_mode),
    .rx_irq    (rx_irq),
    .rx_full   (rx_full),
    .rx_drop   (rx_drop),
    .tx_data   (tx_data),
    .tx_wr_out (tx_wr_out),
    .tx_ready  (tx_ready),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // reference: {overflow, underflow, data} from plain integer arithmetic
  function automatic logic [65:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic [1:0]  m);
    logic [63:0] d;
    logic        o;
    logic        u;
    longint      x;
    longint      y;
    longint      r;
    longint      maxp;
    longint      minn;
    maxp = 64'sd2147483647;
    minn = -64'sd2147483648;
    d = '0;
    o = 1'b0;
    u = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = $signed(a[i*32 +: 32]);
      y = $signed(b[i*32 +: 32]);
      case (m)
        2'd0:    r = x + y;
        2'd1:    r = x - y;
        2'd2:    r = x * y;
        default: r = (x > y) ? x : y;
      endcase
      if (r > maxp) begin
        r = maxp;
        o = 1'b1;
      end else if (r < minn) begin
        r = minn;
        u = 1'b1;
      end
      d[i*32 +: 32] = r[31:0];
    end
    return {o, u, d};
  endfunction

  function automatic logic [31:0] rnd_lane();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'h7FFFFFFF;
      1:       v = 32'h80000000;
      2:       v = 32'($urandom_range(0, 20));
      3:       v = -32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // called at a negedge; strobes one job on the next rising edge
  task automatic push(input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] m);
    rx_data = {a, b};
    rx_mode = m;
    rx_irq  = 1'b1;
    @(negedge clock);
    rx_irq  = 1'b0;
  endtask

  // edges from the strobe until tx_wr_out is seen; 50 means timed out
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!tx_wr_out && lat < 50) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic do_job(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] m, output logic [63:0] d,
                        output logic o, output logic u, output int lat);
    push(a, b, m);
    wait_valid(lat);
    d = tx_data;
    o = overflow;
    u = underflow;
    @(negedge clock);
  endtask

  task automatic test_reset();
    rx_data  = '0;
    rx_mode  = '0;
    rx_irq   = 1'b0;
    tx_ready = 1'b1;
    reset    = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_wr_out, rx_full, rx_drop, overflow, underflow, busy}
        !== 70'd0) begin
      fails++;
      $display("FAIL reset_outputs got data=%h wr=%b full=%b drop=%b ovf=%b unf=%b busy=%b want all 0",
               tx_data, tx_wr_out, rx_full, rx_drop, overflow, underflow, busy);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || tx_wr_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_release busy=%b wr=%b want 0 0", busy, tx_wr_out);
    end
  endtask

  task automatic test_add();
    logic [63:0] d;
    logic        o;
    logic        u;
    int          lat;
    do_job({32'hFFFFFFFE, 32'd5}, {32'd7, 32'd3}, 2'd0, d, o, u, lat);
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL add_latency got %0d want 3", lat);
    end
    checks++;
    if (d !== {32'h00000005, 32'h00000008}) begin
      fails++;
      $display("FAIL add_data got %h want 0000000500000008", d);
    end
    checks++;
    if ({o, u} !== 2'b00) begin
      fails++;
      $display("FAIL add_flags got %b%b want 00", o, u);
    end
    checks++;
    if (tx_wr_out !== 1'b0) begin
      fails++;
      $display("FAIL add_one_cycle tx_wr_out got %b want 0", tx_wr_out);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] d;
    logic        o;
    logic        u;
    int          lat;
    do_job({32'd0, 32'h7FFFFFFF}, {32'd0, 32'd1}, 2'd0, d, o, u, lat);
    checks++;
    if ({o, u, d} !== {2'b10, 32'd0, 32'h7FFFFFFF}) begin
      fails++;
      $display("FAIL sat_add_high got o=%b u=%b d=%h want o=1 u=0 d=000000007fffffff",
               o, u, d);
    end
    do_job({32'h80000000, 32'd0}, {32'd1, 32'd0}, 2'd1, d, o, u, lat);
    checks++;
    if ({o, u, d} !== {2'b01, 32'h80000000, 32'd0}) begin
      fails++;
      $display("FAIL sat_sub_low got o=%b u=%b d=%h want o=0 u=1 d=8000000000000000",
               o, u, d);
    end
  endtask

  task automatic test_mul_max();
    logic [63:0] d;
    logic        o;
    logic        u;
    int          lat;
    do_job({32'hFFFFFFFD, 32'h00010000}, {32'd4, 32'h00010000}, 2'd2,
           d, o, u, lat);
    checks++;
    if ({o, u, d} !== {2'b10, 32'hFFFFFFF4, 32'h7FFFFFFF}) begin
      fails++;
      $display("FAIL mul got o=%b u=%b d=%h want o=1 u=0 d=fffffff47fffffff",
               o, u, d);
    end
    do_job({32'hFFFFFFFF, 32'd9}, {32'hFFFFFFFB, 32'd2}, 2'd3, d, o, u, lat);
    checks++;
    if ({o, u, d} !== {2'b00, 32'hFFFFFFFF, 32'd9}) begin
      fails++;
      $display("FAIL max got o=%b u=%b d=%h want o=0 u=0 d=ffffffff00000009",
               o, u, d);
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  m;
    logic [63:0] d;
    logic        o;
    logic        u;
    logic [65:0] exp;
    int          lat;
    for (int k = 0; k < 24; k++) begin
      a   = {rnd_lane(), rnd_lane()};
      b   = {rnd_lane(), rnd_lane()};
      m   = 2'($urandom_range(0, 3));
      exp = model(a, b, m);
      do_job(a, b, m, d, o, u, lat);
      checks++;
      if ({o, u, d} !== exp || lat !== 3) begin
        fails++;
        $display("FAIL random_%0d mode=%0d got o=%b u=%b d=%h lat=%0d want o=%b u=%b d=%h lat=3",
                 k, m, o, u, d, lat, exp[65], exp[64], exp[63:0]);
      end
    end
    checks++;
    if (rx_drop !== 1'b0) begin
      fails++;
      $display("FAIL random_no_drop rx_drop got %b want 0", rx_drop);
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] expq[$];
    logic [65:0] first;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  m;
    logic [65:0] e;
    int          got;
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = {rnd_lane(), rnd_lane()};
      b = {rnd_lane(), rnd_lane()};
      m = 2'($urandom_range(0, 3));
      if (k < 5) expq.push_back(model(a, b, m));
      rx_data = {a, b};
      rx_mode = m;
      rx_irq  = 1'b1;
      @(negedge clock);
    end
    rx_irq = 1'b0;
    checks++;
    if ({rx_full, rx_drop, tx_wr_out, busy} !== 4'b1111) begin
      fails++;
      $display("FAIL bp_full_drop got full=%b drop=%b wr=%b busy=%b want 1111",
               rx_full, rx_drop, tx_wr_out, busy);
    end
    first = expq[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if ({tx_wr_out, overflow, underflow, tx_data} !== {1'b1, first}) begin
        fails++;
        $display("FAIL bp_hold_%0d got wr=%b o=%b u=%b d=%h want wr=1 o=%b u=%b d=%h",
                 k, tx_wr_out, overflow, underflow, tx_data,
                 first[65], first[64], first[63:0]);
      end
    end
    tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_wr_out) begin
        got++;
        e = (expq.size() > 0) ? expq.pop_front() : 66'h0;
        checks++;
        if ({overflow, underflow, tx_data} !== e) begin
          fails++;
          $display("FAIL bp_result_%0d got o=%b u=%b d=%h want o=%b u=%b d=%h",
                   got, overflow, underflow, tx_data, e[65], e[64], e[63:0]);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (got !== 5) begin
      fails++;
      $display("FAIL bp_count got %0d results want 5", got);
    end
    checks++;
    if ({rx_drop, rx_full, busy} !== 3'b100) begin
      fails++;
      $display("FAIL bp_after got drop=%b full=%b busy=%b want 1 0 0",
               rx_drop, rx_full, busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] d;
    logic        o;
    logic        u;
    int          lat;
    push({32'h7FFFFFFF, 32'h7FFFFFFF}, {32'h7FFFFFFF, 32'h7FFFFFFF}, 2'd2);
    push({32'd1, 32'd2}, {32'd3, 32'd4}, 2'd0);
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_wr_out, rx_full, rx_drop, overflow, underflow, busy}
        !== 70'd0) begin
      fails++;
      $display("FAIL midcalc_reset got data=%h wr=%b full=%b drop=%b ovf=%b unf=%b busy=%b want all 0",
               tx_data, tx_wr_out, rx_full, rx_drop, overflow, underflow, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, tx_wr_out} !== 2'b00) begin
      fails++;
      $display("FAIL midcalc_flushed busy=%b wr=%b want 0 0", busy, tx_wr_out);
    end
    do_job({32'd10, 32'hFFFFFFFF}, {32'd20, 32'd1}, 2'd0, d, o, u, lat);
    checks++;
    if ({o, u, d} !== {2'b00, 32'd30, 32'd0} || lat !== 3) begin
      fails++;
      $display("FAIL midcalc_next got o=%b u=%b d=%h lat=%0d want o=0 u=0 d=0000001e00000000 lat=3",
               o, u, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturation();
    test_mul_max();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
